// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory request/response, redirect, and decode queue head.
// Optional FETCH_MISALIGN_CHECK_EN adds the fetch_misalign status output.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fetch_misalign;

  // Fetch unit side
  modport master (
    output imem_req_valid, imem_addr, instr_valid, instr, instr_pc, fetch_misalign,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
           instr_ready
  );

  // Memory / pipeline side
  modport slave (
    input  imem_req_valid, imem_addr, instr_valid, instr, instr_pc, fetch_misalign,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
           instr_ready
  );
`else
  // Fetch unit side
  modport master (
    output imem_req_valid, imem_addr, instr_valid, instr, instr_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
           instr_ready
  );

  // Memory / pipeline side
  modport slave (
    input  imem_req_valid, imem_addr, instr_valid, instr, instr_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc,
           instr_ready
  );
`endif
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential fetches, tracks in-order responses, buffers them
// in a DEPTH-entry queue for decode, and discards in-flight responses after a redirect.
// Optional macro FETCH_MISALIGN_CHECK_EN: misaligned redirect targets raise a sticky
// fetch_misalign flag and stall fetching until an aligned redirect.
module fetch_unit #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_rsp_pc;
  logic [OutW-1:0] r_outstanding;
  logic [OutW-1:0] r_drop_cnt;
  logic [31:0]   r_q_instr [DEPTH];
  logic [31:0]   r_q_pc    [DEPTH];
  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [CntW-1:0] r_count;

  logic          w_blocked;
  logic          w_req_valid;
  logic          w_req_fire;
  logic          w_rsp;
  logic          w_drop;
  logic          w_push;
  logic          w_pop;
  logic [31:0]   w_redirect_pc;
  logic [OutW-1:0] w_outstanding_nxt;
  logic [OutW-1:0] w_drop_cnt_nxt;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic r_misalign;

  // Sticky misalign flag: each redirect re-evaluates it from the target's low bits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_misalign <= 1'b0;
    end else if (bus.redirect_valid) begin
      r_misalign <= |bus.redirect_pc[1:0];
    end
  end

  assign w_blocked          = r_misalign;
  assign bus.fetch_misalign = r_misalign;
`else
  assign w_blocked = 1'b0;
`endif

  // Low address bits are ignored; instructions are word aligned
  assign w_redirect_pc = bus.redirect_pc & 32'hFFFF_FFFC;

  // Request/response/queue events for this cycle; a redirect cancels push and pop
  always_comb begin
    w_req_valid = reset && !bus.redirect_valid && !w_blocked
                  && (32'(r_outstanding) < MAX_OUTSTANDING)
                  && ((32'(r_outstanding) + 32'(r_count)) < DEPTH);
    w_req_fire  = w_req_valid && bus.imem_req_ready;
    // Responses with nothing in flight cannot belong to us
    w_rsp       = bus.imem_rsp_valid && (r_outstanding != '0);
    w_drop      = w_rsp && (r_drop_cnt != '0);
    w_push      = w_rsp && !w_drop && !bus.redirect_valid;
    w_pop       = (r_count != '0) && bus.instr_ready && !bus.redirect_valid;

    w_outstanding_nxt = r_outstanding + OutW'(w_req_fire) - OutW'(w_rsp);
    w_drop_cnt_nxt    = r_drop_cnt;
    if (bus.redirect_valid) begin
      // Everything still in flight after this edge belongs to the old path
      w_drop_cnt_nxt = r_outstanding - OutW'(w_rsp);
    end else if (w_drop) begin
      w_drop_cnt_nxt = r_drop_cnt - OutW'(1);
    end
  end

  // PC, in-flight and drop tracking
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_outstanding <= w_outstanding_nxt;
      r_drop_cnt    <= w_drop_cnt_nxt;
      if (bus.redirect_valid) begin
        r_fetch_pc <= w_redirect_pc;
        r_rsp_pc   <= w_redirect_pc;
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_push)     r_rsp_pc   <= r_rsp_pc + 32'd4;
      end
    end
  end

  // Queue pointers and occupancy; redirect flushes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (bus.redirect_valid) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PtrW'(1);
      if (w_pop)  r_rptr <= r_rptr + PtrW'(1);
      r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
    end
  end

  // Queue storage; cleared on reset so the head outputs read zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_q_instr[i] <= '0;
        r_q_pc[i]    <= '0;
      end
    end else if (w_push) begin
      r_q_instr[r_wptr] <= bus.imem_rsp_data;
      r_q_pc[r_wptr]    <= r_rsp_pc;
    end
  end

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_addr      = r_fetch_pc;
  assign bus.instr_valid    = (r_count != '0);
  assign bus.instr          = r_q_instr[r_rptr];
  assign bus.instr_pc       = r_q_pc[r_rptr];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a directed vector table, directed corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_fetch_unit;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned MAXO     = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(
    .DEPTH          (DEPTH),
    .MAX_OUTSTANDING(MAXO),
    .RESET_PC       (RESET_PC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] addr;
    bit          stale;
  } pend_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  typedef struct {
    bit          rdy;
    bit          rv;
    logic [31:0] rd;
    bit          redir;
    logic [31:0] rpc;
    bit          ir;
    bit          e_rv;
    logic [31:0] e_addr;
    bit          e_iv;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  // Reference model: requests in flight (in order), decode queue contents, next fetch address
  pend_t       pend [$];
  ent_t        mq   [$];
  logic [31:0] m_fetch = RESET_PC;
  bit          m_mis   = 1'b0;
  int          n_fire  = 0;
  int          n_pop   = 0;
  logic [31:0] popq  [$];
  logic [31:0] fireq [$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    pend.delete();
    mq.delete();
    m_fetch = RESET_PC;
    m_mis   = 1'b0;
  endtask

  // One clock cycle: drive at negedge, check against the model, then advance the model
  task automatic step(input bit rdy, input bit rsp_en, input bit redir,
                      input logic [31:0] rpc, input bit ir);
    bit    rsp;
    bit    exp_rv;
    bit    fire;
    pend_t p;
    ent_t  e;
    @(negedge clk);
    rsp = rsp_en && (pend.size() != 0);
    bus.imem_req_ready = rdy;
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_data  = rsp ? mem_word(pend[0].addr) : 32'($urandom);
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    bus.instr_ready    = ir;
    #1;
    exp_rv = !redir && !m_mis && (pend.size() < int'(MAXO))
             && ((pend.size() + mq.size()) < int'(DEPTH));
    chk("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
    if (exp_rv) chk("imem_addr", bus.imem_addr, m_fetch);
    chk("instr_valid", 32'(bus.instr_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk("instr_pc", bus.instr_pc, mq[0].pc);
      chk("instr", bus.instr, mq[0].data);
    end
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("fetch_misalign", 32'(bus.fetch_misalign), 32'(m_mis));
`endif
    fire = exp_rv && rdy;
    if (redir) begin
      if (rsp) p = pend.pop_front();
      foreach (pend[i]) pend[i].stale = 1'b1;
      mq.delete();
      m_fetch = rpc & 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_CHECK_EN
      m_mis = |rpc[1:0];
`endif
    end else begin
      if (ir && (mq.size() != 0)) begin
        e = mq.pop_front();
        popq.push_back(e.pc);
        n_pop++;
      end
      if (rsp) begin
        p = pend.pop_front();
        if (!p.stale) mq.push_back('{pc: p.addr, data: mem_word(p.addr)});
      end
      if (fire) begin
        pend.push_back('{addr: m_fetch, stale: 1'b0});
        fireq.push_back(m_fetch);
        n_fire++;
        m_fetch = m_fetch + 32'd4;
      end
    end
  endtask

  // Assert reset (responses keep arriving and must be ignored), check reset outputs, release
  task automatic do_reset();
    @(negedge clk);
    reset              = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = 32'hBAD0_BAD0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.instr_ready    = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
      chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
      chk("rst_instr", bus.instr, 32'd0);
      chk("rst_instr_pc", bus.instr_pc, 32'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
      chk("rst_misalign", 32'(bus.fetch_misalign), 32'd0);
`endif
    end
    @(posedge clk);
    #2;
    reset              = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    model_clear();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs [10];

    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.instr_ready    = 1'b0;

    // Stream from reset, then redirect to 0x40 with requests 8 and 12 in flight
    vecs[0] = '{1, 0, 32'h0,           0, 32'h0,  1, 1, 32'h0,  0, 32'h0,  32'h0};
    vecs[1] = '{1, 1, mem_word(32'h0), 0, 32'h0,  1, 1, 32'h4,  0, 32'h0,  32'h0};
    vecs[2] = '{1, 1, mem_word(32'h4), 0, 32'h0,  1, 1, 32'h8,  1, 32'h0,  mem_word(32'h0)};
    vecs[3] = '{1, 0, 32'h0,           0, 32'h0,  1, 1, 32'hC,  1, 32'h4,  mem_word(32'h4)};
    vecs[4] = '{1, 0, 32'h0,           1, 32'h40, 1, 0, 32'h0,  0, 32'h0,  32'h0};
    vecs[5] = '{1, 1, mem_word(32'h8), 0, 32'h0,  1, 0, 32'h0,  0, 32'h0,  32'h0};
    vecs[6] = '{1, 1, mem_word(32'hC), 0, 32'h0,  1, 1, 32'h40, 0, 32'h0,  32'h0};
    vecs[7] = '{1, 1, mem_word(32'h40), 0, 32'h0, 1, 1, 32'h44, 0, 32'h0,  32'h0};
    vecs[8] = '{0, 1, mem_word(32'h44), 0, 32'h0, 1, 1, 32'h48, 1, 32'h40, mem_word(32'h40)};
    vecs[9] = '{0, 0, 32'h0,           0, 32'h0,  0, 1, 32'h48, 1, 32'h44, mem_word(32'h44)};

    do_reset();

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.imem_req_ready = vecs[i].rdy;
      bus.imem_rsp_valid = vecs[i].rv;
      bus.imem_rsp_data  = vecs[i].rd;
      bus.redirect_valid = vecs[i].redir;
      bus.redirect_pc    = vecs[i].rpc;
      bus.instr_ready    = vecs[i].ir;
      #1;
      chk($sformatf("vec%0d_req_valid", i), 32'(bus.imem_req_valid), 32'(vecs[i].e_rv));
      if (vecs[i].e_rv) chk($sformatf("vec%0d_addr", i), bus.imem_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d_instr_valid", i), 32'(bus.instr_valid), 32'(vecs[i].e_iv));
      if (vecs[i].e_iv) begin
        chk($sformatf("vec%0d_instr_pc", i), bus.instr_pc, vecs[i].e_pc);
        chk($sformatf("vec%0d_instr", i), bus.instr, vecs[i].e_instr);
      end
    end

    // Decode stalled: exactly DEPTH requests go out, then drain with no loss
    do_reset();
    n_fire = 0;
    n_pop  = 0;
    repeat (12) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("stall_fires", 32'(n_fire), 32'(DEPTH));
    repeat (12) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("stall_pops_min", 32'(n_pop >= int'(DEPTH)), 32'd1);

    // Redirect coincident with a response and a pop
    repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    popq.delete();
    step(1'b1, 1'b1, 1'b1, 32'h200, 1'b1);
    repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("coinc_pops", 32'(popq.size() >= 2), 32'd1);
    if (popq.size() >= 2) begin
      chk("coinc_first_pc", popq[0], 32'h200);
      chk("coinc_second_pc", popq[1], 32'h204);
    end

    // Address wrap at the top of the address space
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
    popq.delete();
    fireq.delete();
    repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("wrap_counts", 32'((popq.size() >= 3) && (fireq.size() >= 3)), 32'd1);
    if ((popq.size() >= 3) && (fireq.size() >= 3)) begin
      chk("wrap_fire1", fireq[1], 32'hFFFF_FFFC);
      chk("wrap_fire2", fireq[2], 32'h0);
      chk("wrap_pop1", popq[1], 32'hFFFF_FFFC);
      chk("wrap_pop2", popq[2], 32'h0);
    end

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      logic [31:0] rpc;
      rpc = 32'($urandom);
`ifndef FETCH_MISALIGN_CHECK_EN
      if ($urandom_range(0, 1) == 0) rpc = rpc & 32'hFFFF_FFFC;
`else
      if ($urandom_range(0, 3) != 0) rpc = rpc & 32'hFFFF_FFFC;
`endif
      step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 15) == 0, rpc, $urandom_range(0, 2) != 0);
    end

    // Reset with requests in flight: old responses must not leak into the new stream
    step(1'b1, 1'b1, 1'b1, 32'h1000, 1'b1);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    do_reset();
    popq.delete();
    repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("post_reset_pops", 32'(popq.size() >= 1), 32'd1);
    if (popq.size() >= 1) chk("post_reset_first_pc", popq[0], RESET_PC);

`ifdef FETCH_MISALIGN_CHECK_EN
    // Misaligned redirect stalls fetching until an aligned redirect
    step(1'b1, 1'b1, 1'b1, 32'h42, 1'b1);
    n_fire = 0;
    repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("misalign_fires", 32'(n_fire), 32'd0);
    chk("misalign_flag", 32'(bus.fetch_misalign), 32'd1);
    fireq.delete();
    step(1'b1, 1'b1, 1'b1, 32'h44, 1'b1);
    repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    chk("realign_flag", 32'(bus.fetch_misalign), 32'd0);
    chk("realign_fires", 32'(fireq.size() >= 1), 32'd1);
    if (fireq.size() >= 1) chk("realign_addr", fireq[0], 32'h44);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
